serial_addsub_nand: RTL and testbench
=====================================

Name: serial_addsub_nand

Overview:
Parametrised bit-serial adder/subtractor. Its single-bit datapath is a full adder built only from nand primitives, plus a carry flip-flop.
Operands are loaded in parallel and processed LSB-first, one bit per clock. The result is returned in parallel with carry/borrow and signed-overflow flags.
This is the sequential successor to the team's NAND-only combinational half/full adders and is the arithmetic unit for area-constrained datapaths.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)

Ports:
clk       input   1      rising-edge clock
rst       input   1      asynchronous, active-high reset
start     input   1      request operation; sampled only in IDLE
mode      input   1      0 = add (a+b), 1 = subtract (a-b); sampled with start
a         input   WIDTH  operand A; sampled with start
b         input   WIDTH  operand B; sampled with start
busy      output  1      high while operation in progress (RUN)
done      output  1      one-cycle pulse when result valid
result    output  WIDTH  sum/difference; held until next accepted start
cout      output  1      add: carry out; sub: 1 = no borrow (a>=b unsigned)
overflow  output  1      signed (two's complement) overflow of the operation

Behaviour:
- Reset (async, any state): FSM=IDLE; busy=0, done=0, result=0, cout=0, overflow=0; internal shift regs, carry and bit counter cleared. Reset mid-RUN aborts the operation with no done pulse.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1 at an edge:
  - load A_sr<=a; load B_sr<=b, or ~b when mode=1.
  - carry<=mode, so subtract is a + ~b + 1.
  - latch mode; clear result and counter; go to RUN.
- RUN, each edge:
  - bit slice computes s, c from A_sr[0], B_sr[0] and carry.
  - result shifts right with s entering the MSB; A_sr and B_sr shift right.
  - carry<=c; counter++.
  - on the edge processing bit WIDTH-1: capture cout<=c and overflow<=carry_in_msb XOR c; go to DONE.
- DONE: done=1 and busy=0 for exactly one cycle; next edge goes to IDLE. start is ignored in DONE.
- busy=1 exactly in RUN (WIDTH cycles).
- Latency: start accepted at edge k gives done high in the cycle after edge k+WIDTH. Minimum issue interval is WIDTH+2 cycles.
- start while busy or in DONE: ignored. Operands and mode changing during RUN have no effect.
- Outputs result/cout/overflow are stable from DONE until the next accepted start. At that start they clear to 0 and cout/overflow are rewritten at completion.
- Bit slice: nand-only full adder, 9 gates, two cascaded nand half-adder structures with carry merge. No behavioural + or - in the datapath. The control FSM/counter may be behavioural.
- Counter width: $clog2(WIDTH)+1 bits; no wrap inside an operation.

Optional Feature:
SATURATE_EN
- Defined: when the completed operation has overflow=1, result is replaced at the DONE transition by the signed limit.
  - 0 followed by ones (max positive) if the true result is positive, i.e. operand sign (A for add, A for sub) = 0.
  - 1 followed by zeros (max negative) otherwise.
  - overflow flag and cout are still reported unmodified. Latency is unchanged.
- Undefined: result is the wrapped two's-complement value. No extra logic.

Test Plan:
- WIDTH=8, add 8'h35+8'h4A -> result 8'h7F, cout=0, overflow=0; busy high 8 cycles, done pulse 1 cycle at the cycle after edge k+8.
- Add 8'hFF+8'h01 -> result 8'h00, cout=1, overflow=0; sub 8'h10-8'h20 -> result 8'hF0, cout=0 (borrow), overflow=0.
- Add 8'h7F+8'h01 -> overflow=1; result 8'h80 without SATURATE_EN, 8'h7F with it. Sub 8'h80-8'h01 -> overflow=1; result 8'h7F without, 8'h80 with.
- start pulsed with new operands at cycle 3 of RUN and during DONE -> ignored. First result intact; exactly one done pulse.
- rst asserted asynchronously mid-RUN (between edges) -> all outputs 0 immediately, no done. Next start 8'h02+8'h03 -> result 8'h05 with normal latency.
- Back-to-back: start re-asserted in the first IDLE cycle after done -> accepted. Randomised 1000 ops at WIDTH=8 and WIDTH=13 checked against a reference model.

Source files
------------

// File: rtl/serial_addsub_nand.sv
`default_nettype none
// ============================================================================
// Module   : serial_addsub_nand
// Brief    : Bit-serial adder/subtractor with a NAND-only full-adder slice.
//            Operands load in parallel and are processed LSB-first, one bit
//            per clock. The result comes back in parallel with carry/borrow
//            and signed-overflow flags.
// Options  : SATURATE_EN - on signed overflow, clamp the result to the
//            signed limit in the direction of operand A's sign.
// Revision : 1.0 - initial release
// ============================================================================
module serial_addsub_nand #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);

    localparam int               CNT_W  = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q,  state_d;
    logic [WIDTH-1:0]   a_sr_q,   a_sr_d;
    logic [WIDTH-1:0]   b_sr_q,   b_sr_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic               carry_q,  carry_d;
    logic               cout_q,   cout_d;
    logic               ovf_q,    ovf_d;
    logic               busy_q,   busy_d;
    logic               done_q,   done_d;
`ifdef SATURATE_EN
    logic               a_msb_q,  a_msb_d;
`endif

    // Full-adder slice: two NAND half-adder structures plus a NAND carry merge
    wire fa_a  = a_sr_q[0];
    wire fa_b  = b_sr_q[0];
    wire fa_ci = carry_q;
    wire n1, n2, n3, fa_h, n5, n6, n7, fa_s, fa_c;

    nand u_n1 (n1,   fa_a, fa_b);
    nand u_n2 (n2,   fa_a, n1);
    nand u_n3 (n3,   fa_b, n1);
    nand u_n4 (fa_h, n2,   n3);
    nand u_n5 (n5,   fa_h, fa_ci);
    nand u_n6 (n6,   fa_h, n5);
    nand u_n7 (n7,   fa_ci, n5);
    nand u_n8 (fa_s, n6,   n7);
    nand u_n9 (fa_c, n1,   n5);

    // Next-state logic: load on start, shift one bit per RUN cycle, flag at the MSB.
    // Subtraction is folded into the load (inverted B, carry-in of 1), so the
    // mode does not need to be kept once the operation has started.
    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
`ifdef SATURATE_EN
        a_msb_d  = a_msb_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_sr_d   = a;
                    b_sr_d   = mode ? ~b : b;
                    carry_d  = mode;
                    result_d = '0;
                    cout_d   = 1'b0;
                    ovf_d    = 1'b0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = S_RUN;
`ifdef SATURATE_EN
                    a_msb_d  = a[WIDTH-1];
`endif
                end
            end
            S_RUN: begin
                result_d = {fa_s, result_q[WIDTH-1:1]};
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                carry_d  = fa_c;
                cnt_d    = cnt_q + 1'b1;
                busy_d   = 1'b1;
                if (cnt_q == C_LAST) begin
                    // carry_q is the carry into the MSB here
                    cout_d  = fa_c;
                    ovf_d   = carry_q ^ fa_c;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
`ifdef SATURATE_EN
                    if (carry_q ^ fa_c) begin
                        result_d = a_msb_q ? {1'b1, {(WIDTH-1){1'b0}}}
                                           : {1'b0, {(WIDTH-1){1'b1}}};
                    end
`endif
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SATURATE_EN
            a_msb_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef SATURATE_EN
            a_msb_q  <= a_msb_d;
`endif
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_addsub_nand.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_addsub_nand
// Brief    : Self-checking bench for serial_addsub_nand at WIDTH=8 and 13,
//            using an arithmetic reference model and randomised operations.
// Options  : SATURATE_EN - expectations follow the saturating build.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_addsub_nand;

    logic clk = 1'b0;
    logic rst;

    logic        start8, mode8, busy8, done8, cout8, ovf8;
    logic [7:0]  a8, b8, res8;
    logic        start13, mode13, busy13, done13, cout13, ovf13;
    logic [12:0] a13, b13, res13;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    serial_addsub_nand #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .mode(mode8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .result(res8), .cout(cout8), .overflow(ovf8)
    );

    serial_addsub_nand #(.WIDTH(13)) u_dut13 (
        .clk(clk), .rst(rst), .start(start13), .mode(mode13), .a(a13), .b(b13),
        .busy(busy13), .done(done13), .result(res13), .cout(cout13), .overflow(ovf13)
    );

    // Reference: plain integer arithmetic on unsigned and signed views
    function automatic void ref_model(input int w, input bit md, input longint av,
                                      input longint bv, output longint res,
                                      output bit co, output bit ov);
        longint m, sa, sb, t;
        m  = longint'(1) << w;
        sa = (av >= m / 2) ? av - m : av;
        sb = (bv >= m / 2) ? bv - m : bv;
        if (!md) begin
            co = (av + bv) >= m;
            t  = sa + sb;
        end else begin
            co = av >= bv;
            t  = sa - sb;
        end
        ov  = (t > m / 2 - 1) || (t < -(m / 2));
        res = ((t % m) + m) % m;
`ifdef SATURATE_EN
        if (ov) res = (t > 0) ? (m / 2 - 1) : (m / 2);
`endif
    endfunction

    // Issue one operation on the 8-bit unit and wait (bounded) for done
    task automatic do_op8(input bit md, input logic [7:0] aa, input logic [7:0] bb,
                          output logic [7:0] r, output logic co, output logic ov,
                          output int cyc, output int bcnt);
        @(negedge clk);
        start8 = 1'b1; mode8 = md; a8 = aa; b8 = bb;
        @(negedge clk);
        start8 = 1'b0; mode8 = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
        cyc = 1; bcnt = 0;
        while (done8 !== 1'b1 && cyc < 40) begin
            if (busy8 === 1'b1) bcnt++;
            @(negedge clk);
            cyc++;
        end
        r = res8; co = cout8; ov = ovf8;
    endtask

    task automatic do_op13(input bit md, input logic [12:0] aa, input logic [12:0] bb,
                           output logic [12:0] r, output logic co, output logic ov,
                           output int cyc);
        @(negedge clk);
        start13 = 1'b1; mode13 = md; a13 = aa; b13 = bb;
        @(negedge clk);
        start13 = 1'b0; mode13 = 1'($urandom); a13 = 13'($urandom); b13 = 13'($urandom);
        cyc = 1;
        while (done13 !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        r = res13; co = cout13; ov = ovf13;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start8 = 0; mode8 = 0; a8 = 0; b8 = 0;
        start13 = 0; mode13 = 0; a13 = 0; b13 = 0;
        #7;
        n_checks++;
        if ({busy8, done8, res8, cout8, ovf8} !== 12'h000) begin
            n_errors++;
            $display("FAIL reset8: got busy=%b done=%b result=%h cout=%b ovf=%b, want all 0",
                     busy8, done8, res8, cout8, ovf8);
        end
        n_checks++;
        if ({busy13, done13, res13, cout13, ovf13} !== 17'h0) begin
            n_errors++;
            $display("FAIL reset13: got busy=%b done=%b result=%h cout=%b ovf=%b, want all 0",
                     busy13, done13, res13, cout13, ovf13);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        bit         md [5]   = '{0, 0, 1, 0, 1};
        logic [7:0] av [5]   = '{8'h35, 8'hFF, 8'h10, 8'h7F, 8'h80};
        logic [7:0] bv [5]   = '{8'h4A, 8'h01, 8'h20, 8'h01, 8'h01};
`ifdef SATURATE_EN
        logic [7:0] er [5]   = '{8'h7F, 8'h00, 8'hF0, 8'h7F, 8'h80};
`else
        logic [7:0] er [5]   = '{8'h7F, 8'h00, 8'hF0, 8'h80, 8'h7F};
`endif
        logic       ec [5]   = '{0, 1, 0, 0, 1};
        logic       eo [5]   = '{0, 0, 0, 1, 1};
        logic [7:0] r;
        logic       co, ov;
        int         cyc, bcnt;
        for (int i = 0; i < 5; i++) begin
            do_op8(md[i], av[i], bv[i], r, co, ov, cyc, bcnt);
            n_checks++;
            if (r !== er[i] || co !== ec[i] || ov !== eo[i]) begin
                n_errors++;
                $display("FAIL directed[%0d] %h %s %h: got result=%h cout=%b ovf=%b, want %h %b %b",
                         i, av[i], md[i] ? "-" : "+", bv[i], r, co, ov, er[i], ec[i], eo[i]);
            end
            n_checks++;
            if (cyc != 9 || bcnt != 8 || busy8 !== 1'b0) begin
                n_errors++;
                $display("FAIL timing[%0d]: got done at cycle %0d busy cycles %0d busy_in_done=%b, want 9 8 0",
                         i, cyc, bcnt, busy8);
            end
            @(negedge clk);
            n_checks++;
            if (done8 !== 1'b0 || res8 !== er[i]) begin
                n_errors++;
                $display("FAIL hold[%0d]: got done=%b result=%h after pulse, want 0 %h",
                         i, done8, res8, er[i]);
            end
        end
    endtask

    task automatic test_ignored_start();
        int cyc, dones, done_cyc;
        @(negedge clk);
        start8 = 1'b1; mode8 = 1'b0; a8 = 8'h35; b8 = 8'h4A;
        @(negedge clk);
        start8 = 1'b0;
        cyc = 1; dones = 0; done_cyc = 0;
        repeat (30) begin
            if (done8 === 1'b1) begin
                dones++;
                if (dones == 1) done_cyc = cyc;
                start8 = (dones == 1);
                mode8 = 1'b0; a8 = 8'h01; b8 = 8'h01;
            end else begin
                start8 = (cyc == 3);
                mode8 = 1'b1; a8 = 8'h11; b8 = 8'h22;
            end
            @(negedge clk);
            cyc++;
        end
        start8 = 1'b0;
        n_checks++;
        if (dones != 1 || done_cyc != 9) begin
            n_errors++;
            $display("FAIL ignored_start: got %0d done pulses (first at cycle %0d), want 1 at 9",
                     dones, done_cyc);
        end
        n_checks++;
        if (res8 !== 8'h7F || cout8 !== 1'b0 || ovf8 !== 1'b0) begin
            n_errors++;
            $display("FAIL ignored_result: got result=%h cout=%b ovf=%b, want 7f 0 0",
                     res8, cout8, ovf8);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [7:0] r;
        logic       co, ov;
        int         cyc, bcnt, dones;
        @(negedge clk);
        start8 = 1'b1; mode8 = 1'b1; a8 = 8'hF0; b8 = 8'h0F;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy8 !== 1'b1 || res8 === 8'h00) begin
            n_errors++;
            $display("FAIL pre_reset: got busy=%b result=%h mid-run, want busy 1 and partial result nonzero",
                     busy8, res8);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({busy8, done8, res8, cout8, ovf8} !== 12'h000) begin
            n_errors++;
            $display("FAIL async_reset: got busy=%b done=%b result=%h cout=%b ovf=%b, want all 0",
                     busy8, done8, res8, cout8, ovf8);
        end
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        repeat (15) begin
            if (done8 === 1'b1 || busy8 === 1'b1) dones++;
            @(negedge clk);
        end
        n_checks++;
        if (dones != 0) begin
            n_errors++;
            $display("FAIL abort: got %0d cycles of busy/done after reset, want 0", dones);
        end
        do_op8(1'b0, 8'h02, 8'h03, r, co, ov, cyc, bcnt);
        n_checks++;
        if (r !== 8'h05 || co !== 1'b0 || ov !== 1'b0 || cyc != 9) begin
            n_errors++;
            $display("FAIL post_reset_op: got result=%h cout=%b ovf=%b done cycle %0d, want 05 0 0 9",
                     r, co, ov, cyc);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] r;
        logic       co, ov;
        int         cyc, bcnt;
        do_op8(1'b0, 8'h12, 8'h34, r, co, ov, cyc, bcnt);
        n_checks++;
        if (r !== 8'h46 || cyc != 9) begin
            n_errors++;
            $display("FAIL b2b_first: got result=%h done cycle %0d, want 46 9", r, cyc);
        end
        // Called right away: start lands in the first IDLE cycle after done
        do_op8(1'b1, 8'h05, 8'h09, r, co, ov, cyc, bcnt);
        n_checks++;
        if (r !== 8'hFC || co !== 1'b0 || ov !== 1'b0 || cyc != 9) begin
            n_errors++;
            $display("FAIL b2b_second: got result=%h cout=%b ovf=%b done cycle %0d, want fc 0 0 9",
                     r, co, ov, cyc);
        end
    endtask

    task automatic test_random8();
        logic [7:0] av, bv, r;
        logic       co, ov, ec, eo;
        bit         md;
        longint     er;
        int         cyc, bcnt;
        for (int i = 0; i < 1000; i++) begin
            md = 1'($urandom);
            av = 8'($urandom);
            bv = 8'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_op8(md, av, bv, r, co, ov, cyc, bcnt);
            ref_model(8, md, longint'(av), longint'(bv), er, ec, eo);
            n_checks++;
            if (longint'(r) != er || co !== ec || ov !== eo || cyc != 9) begin
                n_errors++;
                $display("FAIL rand8[%0d] %h %s %h: got %h %b %b cyc %0d, want %h %b %b cyc 9",
                         i, av, md ? "-" : "+", bv, r, co, ov, cyc, er[7:0], ec, eo);
            end
        end
    endtask

    task automatic test_random13();
        logic [12:0] av, bv, r;
        logic        co, ov, ec, eo;
        bit          md;
        longint      er;
        int          cyc;
        for (int i = 0; i < 1000; i++) begin
            md = 1'($urandom);
            av = 13'($urandom);
            bv = 13'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_op13(md, av, bv, r, co, ov, cyc);
            ref_model(13, md, longint'(av), longint'(bv), er, ec, eo);
            n_checks++;
            if (longint'(r) != er || co !== ec || ov !== eo || cyc != 14) begin
                n_errors++;
                $display("FAIL rand13[%0d] %h %s %h: got %h %b %b cyc %0d, want %h %b %b cyc 14",
                         i, av, md ? "-" : "+", bv, r, co, ov, cyc, er[12:0], ec, eo);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignored_start();
        test_reset_mid_run();
        test_back_to_back();
        test_random8();
        test_random13();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
